// File: rtl/aes128_cbc_stream_loader.sv
// Streaming loader for an AES-128 CBC core: collects key, IV and plaintext
// words from a 32-bit valid/ready stream, waits a fixed core latency, then
// returns the captured ciphertext block as four output words. Optional
// chaining copies the ciphertext into the IV once the block has drained.
module aes128_cbc_stream_loader #(
    parameter int LATENCY = 22,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_sel,
    input  logic [31:0] in_data,
    input  logic        chain_en,
    output logic [31:0] key_0,
    output logic [31:0] key_1,
    output logic [31:0] key_2,
    output logic [31:0] key_3,
    output logic [31:0] vector_0,
    output logic [31:0] vector_1,
    output logic [31:0] vector_2,
    output logic [31:0] vector_3,
    output logic [31:0] plain_text_0,
    output logic [31:0] plain_text_1,
    output logic [31:0] plain_text_2,
    output logic [31:0] plain_text_3,
    input  logic [31:0] cipher_text_0,
    input  logic [31:0] cipher_text_1,
    input  logic [31:0] cipher_text_2,
    input  logic [31:0] cipher_text_3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t            state_reg, state_next;
    logic [31:0]       key_reg [4];
    logic [31:0]       vec_reg [4];
    logic [31:0]       pt_reg  [4];
    logic [31:0]       cap_reg [4];
    logic [31:0]       ct_w    [4];
    logic [1:0]        k_idx_reg, v_idx_reg, p_idx_reg, o_idx_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              out_valid_reg, out_last_reg;
    logic [31:0]       out_data_reg;
    logic              in_fire, out_fire, cnt_done, block_done;

    assign ct_w[0] = cipher_text_0;
    assign ct_w[1] = cipher_text_1;
    assign ct_w[2] = cipher_text_2;
    assign ct_w[3] = cipher_text_3;

    assign key_0 = key_reg[0];
    assign key_1 = key_reg[1];
    assign key_2 = key_reg[2];
    assign key_3 = key_reg[3];
    assign vector_0 = vec_reg[0];
    assign vector_1 = vec_reg[1];
    assign vector_2 = vec_reg[2];
    assign vector_3 = vec_reg[3];
    assign plain_text_0 = pt_reg[0];
    assign plain_text_1 = pt_reg[1];
    assign plain_text_2 = pt_reg[2];
    assign plain_text_3 = pt_reg[3];

    // in_ready is forced low while reset is asserted, independent of state
    assign in_ready   = reset && (state_reg == ST_LOAD);
    assign busy       = (state_reg == ST_WAIT) || (state_reg == ST_DRAIN);
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_last   = out_last_reg;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_reg && out_ready && (state_reg == ST_DRAIN);
    assign cnt_done   = (cnt_reg == CNT_LAST);
    assign block_done = out_fire && (o_idx_reg == 2'd3);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_LOAD;
        else        state_reg <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD:  if (in_fire && in_sel == 2'b10 && p_idx_reg == 2'd3) state_next = ST_WAIT;
            ST_WAIT:  if (cnt_done) state_next = ST_DRAIN;
            ST_DRAIN: if (block_done) state_next = ST_LOAD;
            default:  state_next = ST_LOAD;
        endcase
    end

    // Core-driving holding registers, load indices and IV chaining
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                key_reg[i] <= '0;
                vec_reg[i] <= '0;
                pt_reg[i]  <= '0;
            end
            k_idx_reg <= '0;
            v_idx_reg <= '0;
            p_idx_reg <= '0;
        end else if (in_fire) begin
            case (in_sel)
                2'b00: begin
                    key_reg[k_idx_reg] <= in_data;
                    k_idx_reg          <= k_idx_reg + 2'd1;
                end
                2'b01: begin
                    vec_reg[v_idx_reg] <= in_data;
                    v_idx_reg          <= v_idx_reg + 2'd1;
                end
                2'b10: begin
                    pt_reg[p_idx_reg] <= in_data;
                    p_idx_reg         <= p_idx_reg + 2'd1;
                end
                default: ;
            endcase
        end else if (block_done && chain_en) begin
            for (int i = 0; i < 4; i++) vec_reg[i] <= cap_reg[i];
        end
    end

    // Latency counter: restarts on the final plaintext word, counts through WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                                  cnt_reg <= '0;
        else if (in_fire && in_sel == 2'b10 && p_idx_reg == 2'd3)    cnt_reg <= '0;
        else if (state_reg == ST_WAIT)                               cnt_reg <= cnt_reg + 1'b1;
    end

    // Ciphertext capture and registered output word sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) cap_reg[i] <= '0;
            o_idx_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else if (state_reg == ST_WAIT && cnt_done) begin
            for (int i = 0; i < 4; i++) cap_reg[i] <= ct_w[i];
            o_idx_reg     <= '0;
            out_valid_reg <= 1'b1;
            out_last_reg  <= 1'b0;
            out_data_reg  <= ct_w[0];
        end else if (out_fire) begin
            if (o_idx_reg == 2'd3) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end else begin
                o_idx_reg    <= o_idx_reg + 2'd1;
                out_data_reg <= cap_reg[o_idx_reg + 2'd1];
                out_last_reg <= (o_idx_reg == 2'd2);
            end
        end
    end

endmodule

// File: tb/tb_aes128_cbc_stream_loader.sv
// Bench for aes128_cbc_stream_loader with a stub core (ciphertext = plaintext
// XOR A5A5A5A5). Load checks are table driven; ciphertext words are pushed to
// a scoreboard queue when a block is sent and popped as the DUT emits them.
module tb_aes128_cbc_stream_loader;

    localparam int LAT = 22;
    localparam logic [31:0] XMASK = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = 2'b00;
    logic [31:0] in_data = '0;
    logic        chain_en = 1'b0;
    logic [31:0] key_0, key_1, key_2, key_3;
    logic [31:0] vector_0, vector_1, vector_2, vector_3;
    logic [31:0] plain_text_0, plain_text_1, plain_text_2, plain_text_3;
    logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    assign cipher_text_0 = plain_text_0 ^ XMASK;
    assign cipher_text_1 = plain_text_1 ^ XMASK;
    assign cipher_text_2 = plain_text_2 ^ XMASK;
    assign cipher_text_3 = plain_text_3 ^ XMASK;

    aes128_cbc_stream_loader #(.LATENCY(LAT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .chain_en(chain_en),
        .key_0(key_0), .key_1(key_1), .key_2(key_2), .key_3(key_3),
        .vector_0(vector_0), .vector_1(vector_1), .vector_2(vector_2), .vector_3(vector_3),
        .plain_text_0(plain_text_0), .plain_text_1(plain_text_1),
        .plain_text_2(plain_text_2), .plain_text_3(plain_text_3),
        .cipher_text_0(cipher_text_0), .cipher_text_1(cipher_text_1),
        .cipher_text_2(cipher_text_2), .cipher_text_3(cipher_text_3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        int          which;   // register group to check afterwards: 0 key, 1 vector
        int          idx;
        logic [31:0] exp;
    } load_vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_word_t;

    exp_word_t   sb_q[$];
    load_vec_t   tbl[10];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [31:0] get_reg(int which, int idx);
        logic [31:0] r;
        r = '0;
        case (which)
            0: case (idx) 0: r = key_0; 1: r = key_1; 2: r = key_2; default: r = key_3; endcase
            1: case (idx) 0: r = vector_0; 1: r = vector_1; 2: r = vector_2; default: r = vector_3; endcase
            default: case (idx) 0: r = plain_text_0; 1: r = plain_text_1; 2: r = plain_text_2; default: r = plain_text_3; endcase
        endcase
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Present one word; returns at the negedge following its acceptance
    task automatic send_word(logic [1:0] sel, logic [31:0] data);
        int wait_cyc;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("in  sel=%0d data=%08h", sel, data);
    endtask

    // Send a plaintext block, queue its expected ciphertext and check latency
    task automatic send_block(logic [31:0] p0, logic [31:0] p1, logic [31:0] p2, logic [31:0] p3);
        logic [31:0] pw[4];
        int cnt;
        int ready_hi;
        pw[0] = p0; pw[1] = p1; pw[2] = p2; pw[3] = p3;
        for (int i = 0; i < 4; i++) begin
            exp_word_t e;
            e.data = pw[i] ^ XMASK;
            e.last = (i == 3);
            sb_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) send_word(2'b10, pw[i]);
        cnt = 0;
        ready_hi = 0;
        while (!out_valid && cnt < 200) begin
            if (in_ready) ready_hi++;
            if (cnt == 5) check("pt_hold_in_wait", plain_text_3, p3);
            cnt++;
            @(negedge clk);
        end
        check("latency_cycles", 32'(cnt), 32'(LAT));
        check("in_ready_low_in_wait", 32'(ready_hi), 32'd0);
        check("busy_in_drain", {31'd0, busy}, 32'd1);
    endtask

    // Drain one block from the DUT (starts at a negedge with out_valid high)
    task automatic drain(bit bp);
        int cyc, got;
        bit have_hold;
        logic [31:0] hold_data;
        logic hold_last;
        int extra;
        cyc = 0; got = 0; have_hold = 0; hold_data = '0; hold_last = 1'b0;
        while (got < 4 && cyc < 200) begin
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (have_hold) begin
                check("hold_data", out_data, hold_data);
                check("hold_last", {31'd0, out_last}, {31'd0, hold_last});
            end
            if (!out_valid) begin
                check("drain_valid", 32'd0, 32'd1);
            end else if (out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", out_data, 32'd0);
                end else begin
                    exp_word_t e;
                    e = sb_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", {31'd0, out_last}, {31'd0, e.last});
                end
                $display("out data=%08h last=%0d", out_data, out_last);
                got++;
                have_hold = 0;
            end else begin
                have_hold = 1;
                hold_data = out_data;
                hold_last = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_word_count", 32'(got), 32'd4);
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("no_extra_words", 32'(extra), 32'd0);
        check("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] vsave[4];
        int seen;

        tbl[0] = '{2'b00, 32'h03020100, 0, 0, 32'h03020100};
        tbl[1] = '{2'b00, 32'h07060504, 0, 1, 32'h07060504};
        tbl[2] = '{2'b11, 32'hDEADBEEF, 0, 2, 32'h00000000};
        tbl[3] = '{2'b00, 32'h0B0A0908, 0, 2, 32'h0B0A0908};
        tbl[4] = '{2'b00, 32'h0F0E0D0C, 0, 3, 32'h0F0E0D0C};
        tbl[5] = '{2'b01, 32'h11111111, 1, 0, 32'h11111111};
        tbl[6] = '{2'b11, 32'hCAFEF00D, 1, 1, 32'h00000000};
        tbl[7] = '{2'b01, 32'h00000000, 1, 1, 32'h00000000};
        tbl[8] = '{2'b01, 32'h00000000, 1, 2, 32'h00000000};
        tbl[9] = '{2'b01, 32'h00000000, 1, 3, 32'h00000000};

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        for (int g = 0; g < 3; g++)
            for (int i = 0; i < 4; i++) check("rst_reg", get_reg(g, i), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
        check("busy_after_release", {31'd0, busy}, 32'd0);

        // Table-driven key/IV loading, including reserved-select words
        for (int t = 0; t < 10; t++) begin
            send_word(tbl[t].sel, tbl[t].data);
            check("load_reg", get_reg(tbl[t].which, tbl[t].idx), tbl[t].exp);
            check("load_in_ready", {31'd0, in_ready}, 32'd1);
        end
        // Vector word 0 goes back to zero after the v_idx wrap
        send_word(2'b01, 32'h00000000);
        check("vec_wrap", vector_0, 32'd0);

        // Block 1: no chaining, no backpressure
        chain_en = 1'b0;
        send_block(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004);
        drain(1'b0);
        for (int i = 0; i < 4; i++) check("vec_no_chain", get_reg(1, i), 32'd0);
        check("key_kept", key_3, 32'h0F0E0D0C);

        // Block 2: chaining with 1,0,0,1 backpressure
        chain_en = 1'b1;
        send_block(32'h00000010, 32'h00000020, 32'h00000030, 32'h00000040);
        drain(1'b1);
        check("chain_v0", vector_0, 32'h00000010 ^ XMASK);
        check("chain_v1", vector_1, 32'h00000020 ^ XMASK);
        check("chain_v2", vector_2, 32'h00000030 ^ XMASK);
        check("chain_v3", vector_3, 32'h00000040 ^ XMASK);

        // Block 3: chaining turned off again leaves the chained IV in place
        chain_en = 1'b0;
        for (int i = 0; i < 4; i++) vsave[i] = get_reg(1, i);
        send_block(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'hFFFFFFFF);
        drain(1'b1);
        for (int i = 0; i < 4; i++) check("vec_unchanged", get_reg(1, i), vsave[i]);

        // Abort: reset asserted ten cycles into WAIT
        for (int i = 0; i < 4; i++) send_word(2'b10, 32'h00000100 + 32'(i));
        repeat (9) @(negedge clk);
        check("abort_in_wait", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        for (int g = 0; g < 3; g++)
            for (int i = 0; i < 4; i++) check("abort_reg_clear", get_reg(g, i), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_release_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        out_ready = 1'b0;
        check("abort_no_output", 32'(seen), 32'd0);

        // Plaintext index restarted at 0 after the abort
        send_word(2'b10, 32'hAAAA0000);
        check("abort_pidx_reset", plain_text_0, 32'hAAAA0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_cbc_stream_loader.md
Name: aes128_cbc_stream_loader

Overview:
Streaming front/back end for aes128_cbc_top. It accepts a 32-bit word stream with valid/ready and loads key, IV and plaintext words into holding registers that drive the core's key_*, vector_* and plain_text_* inputs. After a fixed core latency it captures cipher_text_0..3 and returns them as a 4-word output stream. Optional CBC chaining replaces the IV with the last ciphertext block.

Parameters:
LATENCY, 22, cycles from the final plaintext word accepted to cipher_text_* valid at the core outputs; legal range 1..63.
CNT_W, 6, width of the latency counter; must satisfy 2^CNT_W > LATENCY.

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
in_valid  in  1  input word valid
in_ready  out  1  loader can accept a word
in_sel  in  2  target of the word: 00 key, 01 IV, 10 plaintext, 11 reserved
in_data  in  32  word payload
chain_en  in  1  1 = IV <= ciphertext after each block
key_0..key_3  out  32 each  to core key_0..3
vector_0..vector_3  out  32 each  to core vector_0..3
plain_text_0..plain_text_3  out  32 each  to core plain_text_0..3
cipher_text_0..cipher_text_3  in  32 each  from core cipher_text_0..3
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts the output word
out_data  out  32  ciphertext word
out_last  out  1  high on the 4th word of a block
busy  out  1  high in WAIT or DRAIN

Behaviour:
- Reset (reset=0, async): state=LOAD; all key/vector/plain_text regs=0; k_idx, v_idx, p_idx, o_idx=0; latency cnt=0; capture reg=0; out_valid=0, out_last=0, out_data=0, busy=0; in_ready=0 while reset=0.
- Word mapping: index n writes reg word n, i.e. key_n/vector_n/plain_text_n (word 0 = bits[31:0] of the 128-bit value).
- States: LOAD, WAIT, DRAIN.
- LOAD: in_ready=1. On in_valid & in_ready:
  - sel 00 writes key[k_idx], k_idx++ mod 4.
  - sel 01 writes vector[v_idx], v_idx++ mod 4.
  - sel 11 is accepted and discarded; no register changes.
  - sel 10 writes plain_text[p_idx]; if p_idx==3 then p_idx=0, cnt=0, go to WAIT; else p_idx++.
- Key/IV may be reloaded any time in LOAD, including between plaintext words. Partial key/IV loads simply overwrite the indexed words; no check is made.
- WAIT: in_ready=0; cnt++ each cycle. In the cycle where cnt==LATENCY-1, capture cipher_text_0..3 into the capture reg, set o_idx=0, go to DRAIN. This gives exactly LATENCY cycles between the plaintext-3 handshake edge and the capture edge. All core-driving regs are held stable throughout WAIT.
- DRAIN: out_valid=1; out_data=capture[o_idx]; out_last=(o_idx==3). On out_ready, o_idx++. Without out_ready, out_data and out_last hold stable; the source never retracts valid.
  - On the handshake with o_idx==3: if chain_en=1, vector_n <= capture word n (all 4) in the same edge. Then go to LOAD, out_valid=0.
  - chain_en is sampled only on that edge.
- Outputs out_valid, out_data, out_last are registered (no combinational path from out_ready). in_ready and busy are decoded from state and reset only.
- Reset mid-WAIT or mid-DRAIN aborts the block; no partial output follows reset release. The first cycle after release is LOAD with in_ready=1.
- Simultaneous events: none are possible across states, since input and output handshakes are mutually exclusive by state.

Test Plan:
- Reset and defaults: hold reset=0 for 3 cycles, release -> all outputs 0, in_ready=1 next cycle, busy=0.
- Load: key words 03020100,07060504,0B0A0908,0F0E0D0C then IV 0,0,0,0 -> key_0=03020100 .. key_3=0F0E0D0C; vector_* = 0; in_ready stays 1.
- Latency and drain: stub core drives cipher_text_n = plain_text_n ^ 0xA5A5A5A5; send PT words 00000001..00000004 -> in_ready low for exactly LATENCY (22) cycles; out_data A5A5A5A4, A5A5A5A7, A5A5A5A6, A5A5A5A1, with out_last only on the 4th.
- Backpressure: out_ready toggling 1,0,0,1… -> each word held stable while ready=0; exactly 4 words; no duplicates or drops.
- Chaining: chain_en=1, two blocks -> after block 1 vector_n equals block-1 ciphertext word n. With chain_en=0, vector is unchanged.
- Abort and reserved select: assert reset at WAIT cycle 10 -> out_valid never rises, registers clear. A sel=11 word in LOAD -> accepted and ignored, all indices unchanged.
